// File: rtl/rr_arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux_pkg
// Description : Shared definitions for the parametrised arbitration datapath.
//               Provides the arbitration mode encoding, a constant-foldable
//               ceil(log2) and the select-index width helper (never below 1).
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_mux_pkg;

    typedef enum logic [0:0] {
        ARB_ROUND_ROBIN = 1'b0,
        ARB_FIXED       = 1'b1
    } arb_mode_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of a channel index; a single channel still needs one bit.
    function automatic int sel_width(input int num);
        return (clog2(num) < 1) ? 1 : clog2(num);
    endfunction

endpackage : rr_arb_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational one-hot grant generator. Searches upward from
//               ptr (wrapping) for the first asserted request; with
//               fixed_prio set the search always starts at index 0.
// Ports       : req        in  N      request vector
//               ptr        in  PTR_W  search start index (round-robin)
//               fixed_prio in  1      1 = lowest index wins
//               grant      out N      one-hot grant, zero when req == 0
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             fixed_prio,
    output logic [N-1:0]     grant
);

    logic [PTR_W-1:0] w_base;
    logic [2*N-1:0]   w_req_dbl;
    logic [N-1:0]     w_req_rot;
    logic [N-1:0]     w_first;
    logic             w_found;
    logic [2*N-1:0]   w_gnt_dbl;

    assign w_base = fixed_prio ? '0 : ptr;

    // Rotate the request vector so that index w_base sits at bit 0; the
    // doubled copy supplies the wrapped-around upper channels.
    assign w_req_dbl = {req, req};
    assign w_req_rot = N'(w_req_dbl >> w_base);

    // Lowest set bit of the rotated vector is the winner.
    always_comb begin
        w_first = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_req_rot[i] && !w_found) begin
                w_first[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    // Rotate the winner back; a bit that overflows past N-1 folds to the
    // low half.
    assign w_gnt_dbl = {{N{1'b0}}, w_first} << w_base;
    assign grant     = w_gnt_dbl[N-1:0] | w_gnt_dbl[2*N-1:N];

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux
// Description : N-to-1 arbitrated multiplexer with a single registered output
//               stage. Round-robin or fixed-priority selection; accepts one
//               word per cycle while the output stage drains.
// Ports       : clk       in  1             rising-edge clock
//               reset     in  1             synchronous active-high reset
//               in_valid  in  NUM_IN        per-channel request
//               in_data   in  NUM_IN*WIDTH  channel i at [i*WIDTH +: WIDTH]
//               in_ready  out NUM_IN        one-hot accept strobe
//               out_valid out 1             output register occupied
//               out_data  out WIDTH         registered selected word
//               out_sel   out SEL_W         source channel of out_data
//               out_ready in  1             downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int NUM_IN     = 4,
    parameter  int FIXED_PRIO = 0,
    localparam int SEL_W      = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    localparam arb_mode_e c_mode = (FIXED_PRIO != 0) ? ARB_FIXED : ARB_ROUND_ROBIN;

    logic [SEL_W-1:0]  r_ptr;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;

    logic [NUM_IN-1:0] w_grant;
    logic              w_load_en;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_sel_data;
    logic [SEL_W-1:0]  w_sel_idx;
    logic [SEL_W-1:0]  w_next_ptr;

    rr_arbiter #(
        .N     (NUM_IN),
        .PTR_W (SEL_W)
    ) u_arbiter (
        .req        (in_valid),
        .ptr        (r_ptr),
        .fixed_prio (c_mode == ARB_FIXED),
        .grant      (w_grant)
    );

    // The output register can take a new word when empty or being drained.
    // Reset also blocks acceptance so no word slips in during reset.
    assign w_load_en = ~r_out_valid | out_ready;
    assign in_ready  = w_grant & {NUM_IN{w_load_en & ~reset}};
    assign w_xfer    = |in_ready;

    // AND-OR select: the one-hot grant masks each slice.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

    // One-hot to index encoding.
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) begin
                w_sel_idx = w_sel_idx | SEL_W'(i);
            end
        end
    end

    // Pointer moves just past the winner, wrapping at the last channel.
    assign w_next_ptr = (w_sel_idx == SEL_W'(NUM_IN - 1)) ? '0 : (w_sel_idx + SEL_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_sel_idx;
            if (c_mode == ARB_ROUND_ROBIN) begin
                r_ptr <= w_next_ptr;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule : rr_arb_mux
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_mux
// Description : Self-checking bench for rr_arb_mux. Drives a round-robin and a
//               fixed-priority 4x32 instance from shared stimulus, compares
//               both against a behavioural model, runs a directed vector
//               table, then streams random traffic through a 1x8 instance
//               against a FIFO scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 4-channel instances
    logic         rst;
    logic [3:0]   v;
    logic [127:0] d;
    logic         ordy;

    logic [3:0]  a_rdy, b_rdy;
    logic        a_ov, b_ov;
    logic [31:0] a_od, b_od;
    logic [1:0]  a_os, b_os;

    // Single-channel instance
    logic       c_rst, c_v, c_rdy, c_ordy, c_ov;
    logic [7:0] c_d, c_od;
    logic [0:0] c_os;

    rr_arb_mux #(.WIDTH(32), .NUM_IN(4), .FIXED_PRIO(0)) u_dut_rr (
        .clk(clk), .reset(rst), .in_valid(v), .in_data(d), .in_ready(a_rdy),
        .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(ordy));

    rr_arb_mux #(.WIDTH(32), .NUM_IN(4), .FIXED_PRIO(1)) u_dut_fx (
        .clk(clk), .reset(rst), .in_valid(v), .in_data(d), .in_ready(b_rdy),
        .out_valid(b_ov), .out_data(b_od), .out_sel(b_os), .out_ready(ordy));

    rr_arb_mux #(.WIDTH(8), .NUM_IN(1), .FIXED_PRIO(0)) u_dut_one (
        .clk(clk), .reset(c_rst), .in_valid(c_v), .in_data(c_d), .in_ready(c_rdy),
        .out_valid(c_ov), .out_data(c_od), .out_sel(c_os), .out_ready(c_ordy));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of the 4-channel instances: index 0 = round-robin,
    // index 1 = fixed priority.
    int          mv [2];
    logic [31:0] md [2];
    int          ms [2];
    int          mp [2];

    // First requesting channel at or after 'base', wrapping modulo 4.
    function automatic int pick(input logic [3:0] req, input int base);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (base + k) % 4;
            if (((req >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] chdata(input int ch);
        case (ch)
            0:       return 32'hAAAA0000;
            1:       return 32'h11111111;
            2:       return 32'h22222222;
            default: return 32'h33333333;
        endcase
    endfunction

    // Called with inputs already applied (just after an edge). Checks the
    // combinational in_ready, clocks once, updates the model and checks the
    // registered outputs.
    task automatic step_ab(output logic [3:0] ra, output logic [3:0] rb);
        int         g [2];
        logic [3:0] er [2];
        logic       was_rst;
        #1;
        for (int m = 0; m < 2; m++) begin
            g[m]  = pick(v, (m == 1) ? 0 : mp[m]);
            er[m] = (!rst && g[m] >= 0 && (mv[m] == 0 || ordy)) ? (4'b0001 << g[m]) : 4'b0000;
        end
        ra = a_rdy;
        rb = b_rdy;
        chk("rr_in_ready", a_rdy, er[0]);
        chk("fx_in_ready", b_rdy, er[1]);
        was_rst = rst;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mv[m] = 0; md[m] = '0; ms[m] = 0; mp[m] = 0;
            end else if (er[m] != 4'b0000) begin
                mv[m] = 1;
                md[m] = d[g[m]*32 +: 32];
                ms[m] = g[m];
                mp[m] = (m == 1) ? 0 : (g[m] + 1) % 4;
            end else if (ordy) begin
                mv[m] = 0;
            end
        end
        #1;
        chk("rr_out_valid", a_ov, mv[0]);
        chk("fx_out_valid", b_ov, mv[1]);
        if (mv[0] != 0 || was_rst) begin
            chk("rr_out_data", a_od, md[0]);
            chk("rr_out_sel",  a_os, ms[0]);
        end
        if (mv[1] != 0 || was_rst) begin
            chk("fx_out_data", b_od, md[1]);
            chk("fx_out_sel",  b_os, ms[1]);
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] vin;
        logic       o;
        logic [3:0] er;
        logic       eov;
        logic [1:0] es;
    } vec_t;

    vec_t tbl [23];

    initial begin
        logic [3:0] ra, rb;
        byte unsigned q [$];
        byte unsigned nxt;
        byte unsigned exp_b;
        int sent, recv;
        logic xin, xout, exp_ov;

        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; md[m] = '0; ms[m] = 0; mp[m] = 0;
        end

        //          rst vin     ordy er      eov es
        tbl[0]  = '{1, 4'b0000, 1, 4'b0000, 0, 0};
        tbl[1]  = '{0, 4'b0001, 1, 4'b0001, 1, 0};
        tbl[2]  = '{1, 4'b1111, 1, 4'b0000, 0, 0};
        tbl[3]  = '{0, 4'b1111, 1, 4'b0001, 1, 0};
        tbl[4]  = '{0, 4'b1111, 1, 4'b0010, 1, 1};
        tbl[5]  = '{0, 4'b1111, 1, 4'b0100, 1, 2};
        tbl[6]  = '{0, 4'b1111, 1, 4'b1000, 1, 3};
        tbl[7]  = '{0, 4'b1111, 1, 4'b0001, 1, 0};
        tbl[8]  = '{0, 4'b1111, 1, 4'b0010, 1, 1};
        tbl[9]  = '{0, 4'b1111, 1, 4'b0100, 1, 2};
        tbl[10] = '{0, 4'b1111, 1, 4'b1000, 1, 3};
        tbl[11] = '{0, 4'b0110, 0, 4'b0000, 1, 3};
        tbl[12] = '{0, 4'b0110, 0, 4'b0000, 1, 3};
        tbl[13] = '{0, 4'b0110, 0, 4'b0000, 1, 3};
        tbl[14] = '{0, 4'b0110, 1, 4'b0010, 1, 1};
        tbl[15] = '{0, 4'b0110, 1, 4'b0100, 1, 2};
        tbl[16] = '{0, 4'b0000, 1, 4'b0000, 0, 0};
        tbl[17] = '{0, 4'b0000, 0, 4'b0000, 0, 0};
        tbl[18] = '{0, 4'b0100, 0, 4'b0100, 1, 2};
        tbl[19] = '{0, 4'b0100, 0, 4'b0000, 1, 2};
        tbl[20] = '{1, 4'b1000, 0, 4'b0000, 0, 0};
        tbl[21] = '{0, 4'b1001, 1, 4'b0001, 1, 0};
        tbl[22] = '{0, 4'b1000, 1, 4'b1000, 1, 3};

        rst  = 1'b1;
        v    = 4'b0000;
        d    = {chdata(3), chdata(2), chdata(1), chdata(0)};
        ordy = 1'b1;
        c_rst = 1'b1; c_v = 1'b0; c_d = 8'h00; c_ordy = 1'b0;

        // Directed vector table on the round-robin instance
        for (int i = 0; i < 23; i++) begin
            rst  = tbl[i].r;
            v    = tbl[i].vin;
            ordy = tbl[i].o;
            step_ab(ra, rb);
            chk($sformatf("vec%0d_in_ready", i), ra, tbl[i].er);
            chk($sformatf("vec%0d_out_valid", i), a_ov, tbl[i].eov);
            if (tbl[i].eov) begin
                chk($sformatf("vec%0d_out_sel", i), a_os, tbl[i].es);
                chk($sformatf("vec%0d_out_data", i), a_od, chdata(int'(tbl[i].es)));
            end else if (tbl[i].r) begin
                chk($sformatf("vec%0d_rst_data", i), a_od, 32'h0);
            end
        end

        // Fixed priority: channel 1 always beats channel 3
        rst = 1'b1; v = 4'b0000; ordy = 1'b1;
        step_ab(ra, rb);
        rst = 1'b0; v = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            step_ab(ra, rb);
            chk("fx_grant_ch1", rb, 4'b0010);
            chk("fx_sel_ch1", b_os, 2'd1);
        end

        // Randomised traffic on both 4-channel instances
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            v    = 4'($urandom);
            d    = {$urandom, $urandom, $urandom, $urandom};
            ordy = ($urandom_range(0, 3) != 0);
            step_ab(ra, rb);
        end
        rst = 1'b0; v = 4'b0000;

        // Single-channel pipeline register against a FIFO scoreboard
        @(posedge clk); #1;
        c_rst = 1'b1;
        @(posedge clk); #1;
        chk("one_rst_valid", c_ov, 1'b0);
        chk("one_rst_data", c_od, 8'h00);
        chk("one_rst_sel", c_os, 1'b0);
        chk("one_rst_ready", c_rdy, 1'b0);
        c_rst = 1'b0;
        nxt = 8'd0; sent = 0; recv = 0;
        for (int i = 0; i < 1000; i++) begin
            c_v    = ($urandom_range(0, 2) != 0);
            c_d    = nxt;
            c_ordy = ($urandom_range(0, 2) != 0);
            #3;
            exp_ov = (q.size() != 0);
            chk("one_out_valid", c_ov, exp_ov);
            chk("one_in_ready", c_rdy, c_v && (!exp_ov || c_ordy));
            xin  = c_v && c_rdy;
            xout = c_ov && c_ordy;
            if (xout) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL one_underflow: got out_valid=1 expected empty");
                end else begin
                    exp_b = q.pop_front();
                    chk("one_out_data", c_od, exp_b);
                    chk("one_out_sel", c_os, 1'b0);
                    recv++;
                end
            end
            if (xin) begin
                q.push_back(nxt);
                nxt = nxt + 8'd1;
                sent++;
            end
            @(posedge clk); #1;
        end
        chk("one_word_count", recv + q.size(), sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arb_mux
`default_nettype wire
